// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared timing helpers and arbiter state encoding for the usart_tx arbiter
package usart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    function automatic int calc_s_cnt(input int s_clk, input int bounds);
        return s_clk / bounds;
    endfunction

    // One frame slot: 10 bit times plus margin for the serializer's input sync.
    function automatic int calc_frame_cyc(input int s_clk, input int bounds);
        return 10 * calc_s_cnt(s_clk, bounds) + 4;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req scanning upward from ptr+1
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);

    always_comb begin
        logic found;
        int   cand;
        found = 1'b0;
        cand  = 0;
        any   = |req;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                idx   = cand[PW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usart_tx_arb.sv
// rtl/usart_tx_arb.sv - round-robin sequencer sharing one usart_tx among N_REQ byte requesters
module usart_tx_arb
    import usart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int BOUNDS = 115200,
    parameter int S_CLK  = 50_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [7:0]               tx_data,
    output logic                     tx_en
);

    localparam int PW        = $clog2(N_REQ);
    localparam int FRAME_CYC = calc_frame_cyc(S_CLK, BOUNDS);
    localparam int TW        = $clog2(FRAME_CYC);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYC - 1);
    localparam logic [PW-1:0] PTR_RESET  = PW'(N_REQ - 1);

    arb_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [PW-1:0] ptr;
    logic          pick_any;
    logic [PW-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Reset lands in WAIT with a full slot so a frame already in flight can finish.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= ST_WAIT;
            timer   <= TIMER_LOAD;
            ptr     <= PTR_RESET;
            owner   <= '0;
            tx_data <= 8'h00;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (state == ST_IDLE && pick_any) begin
                owner   <= pick_idx;
                ptr     <= pick_idx;
                tx_data <= req_data[{pick_idx, 3'b000} +: 8];
            end
        end
    end

    // The timer runs through START as well, so START+WAIT together span exactly FRAME_CYC cycles.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        ack      = '0;
        tx_en    = 1'b0;
        busy     = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_any) begin
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ack[owner] = 1'b1;
                timer_nx   = TIMER_LOAD;
                state_nx   = ST_START;
            end
            ST_START: begin
                tx_en    = 1'b1;
                timer_nx = timer - 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
